// File: rtl/demux_1_16_reg_pkg.sv
// Shared constants and mode encoding for the registered 1:16 demultiplexer.
package demux_pkg;

    localparam int unsigned WIDTH    = 6;
    localparam int unsigned CHANNELS = 16;
    localparam int unsigned SEL_W    = $clog2(CHANNELS);

    // MANUAL: select picks the channel; AUTO: round-robin pointer picks it.
    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_1_16_reg_if.sv
// Producer/consumer bundle of the 1:16 demultiplexer.
// master = the environment (producer plus consumers), slave = the demux.
interface demux_1_16_reg_if #(
    parameter int unsigned WIDTH    = demux_pkg::WIDTH,
    parameter int unsigned CHANNELS = demux_pkg::CHANNELS
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    // Producer side
    logic [WIDTH-1:0]          datain;
    logic [SEL_W-1:0]          select;
    logic                      in_valid;
    logic                      in_ready;
    logic                      auto_mode;

    // Consumer side
    logic [CHANNELS*WIDTH-1:0] dataout;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ack;

    // Status
    logic                      frame_done;
    logic                      overrun;

    modport master (
        output datain, select, in_valid, auto_mode, out_ack,
        input  in_ready, dataout, out_valid, frame_done, overrun
    );

    modport slave (
        input  datain, select, in_valid, auto_mode, out_ack,
        output in_ready, dataout, out_valid, frame_done, overrun
    );

endinterface

// File: rtl/demux_1_16_reg_slot.sv
// One holding register of the demux: data word plus valid flag, drained by ack.
module demux_channel_slot #(
    parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Write wins over ack so a same-cycle ack+write passes through without a bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

    // Holding register and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;
    // A slot can take a new word if empty or being drained this cycle.
    assign busy  = valid_q & ~ack;

endmodule

// File: rtl/demux_1_16_reg.sv
// Registered 1:16 demultiplexer: steers a producer stream into per-channel
// holding registers chosen by select (MANUAL) or a round-robin pointer (AUTO).
module demux_1_16_reg #(
    parameter int unsigned WIDTH    = demux_pkg::WIDTH,
    parameter int unsigned CHANNELS = demux_pkg::CHANNELS
) (
    input logic              clk,
    input logic              rst,
    demux_1_16_reg_if.slave  bus
);
    import demux_pkg::*;

    localparam int unsigned SEL_W = $clog2(CHANNELS);

    mode_e               state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;

    logic [SEL_W-1:0]    tgt;
    logic                in_ready;
    logic                accept;
    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] valid;
    logic [WIDTH-1:0]    slot_q [CHANNELS];

    // Target channel and producer handshake; no path from in_valid to in_ready.
    always_comb begin
        tgt      = (state_q == AUTO) ? ptr_q : bus.select;
        in_ready = ~busy[tgt];
        accept   = bus.in_valid & in_ready;
    end

    // One-hot write enable for the accepted word.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr_en[i] = accept && (tgt == SEL_W'(i));
        end
    end

    // Mode FSM, pointer advance, frame completion and overrun detection.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        case (state_q)
            MANUAL: begin
                if (bus.in_valid && !in_ready) begin
                    overrun_d = 1'b1;
                end
                if (bus.auto_mode) begin
                    state_d = AUTO;
                    ptr_d   = '0;
                end
            end
            AUTO: begin
                if (accept) begin
                    ptr_d        = ptr_q + SEL_W'(1);
                    frame_done_d = (ptr_q == SEL_W'(CHANNELS - 1));
                end
                // Judged on the next pointer so the wrapping accept hands over
                // straight to MANUAL instead of starting another frame.
                if (!bus.auto_mode && (ptr_d == '0)) begin
                    state_d = MANUAL;
                end
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MANUAL;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
        demux_channel_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr_en[g]),
            .ack   (bus.out_ack[g]),
            .d     (bus.datain),
            .q     (slot_q[g]),
            .valid (valid[g]),
            .busy  (busy[g])
        );
        assign bus.dataout[g*WIDTH +: WIDTH] = slot_q[g];
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_demux_1_16_reg.sv
// Scenario bench for demux_1_16_reg: accepted words are queued as expectations
// and checked against the holding registers once the DUT has registered them.
module tb_demux_1_16_reg;

    typedef struct {
        int         ch;
        logic [5:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    exp_t sb[$];
    exp_t e;

    demux_1_16_reg_if #(.WIDTH(6), .CHANNELS(16)) bus ();

    demux_1_16_reg #(.WIDTH(6), .CHANNELS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] chan(input int i);
        return bus.dataout[i*6 +: 6];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.datain = '0; bus.select = '0; bus.in_valid = 1'b0;
        bus.auto_mode = 1'b0; bus.out_ack = '0;
        #2;
        n_cmp++; if (bus.out_valid !== 16'h0000) begin n_mis++; $display("FAIL reset_out_valid got=%h exp=0000", bus.out_valid); end
        n_cmp++; if (bus.dataout !== 96'h0) begin n_mis++; $display("FAIL reset_dataout got=%h exp=0", bus.dataout); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_mis++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_mis++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_manual_write();
        bus.select = 4'd5; bus.datain = 6'h2A; bus.in_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL man_in_ready got=%b exp=1", bus.in_ready); end
        sb.push_back('{5, 6'h2A});
        tick();
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (bus.out_valid !== 16'h0020) begin n_mis++; $display("FAIL man_out_valid got=%h exp=0020", bus.out_valid); end
        n_cmp++; if (chan(e.ch) !== e.data) begin n_mis++; $display("FAIL man_data ch=%0d got=%h exp=%h", e.ch, chan(e.ch), e.data); end
        bus.out_ack[5] = 1'b1;
        tick();
        bus.out_ack = '0;
        n_cmp++; if (bus.out_valid !== 16'h0000) begin n_mis++; $display("FAIL man_ack_valid got=%h exp=0000", bus.out_valid); end
        n_cmp++; if (chan(5) !== 6'h2A) begin n_mis++; $display("FAIL man_ack_retain got=%h exp=2a", chan(5)); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_mis++; $display("FAIL man_overrun got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_overrun();
        bus.select = 4'd3; bus.datain = 6'h07; bus.in_valid = 1'b1;
        sb.push_back('{3, 6'h07});
        tick();
        e = sb.pop_front();
        n_cmp++; if (chan(e.ch) !== e.data) begin n_mis++; $display("FAIL ovr_fill ch=%0d got=%h exp=%h", e.ch, chan(e.ch), e.data); end
        bus.datain = 6'h11;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL ovr_stall_ready got=%b exp=0", bus.in_ready); end
        tick();
        n_cmp++; if (bus.overrun !== 1'b1) begin n_mis++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
        n_cmp++; if (chan(3) !== 6'h07) begin n_mis++; $display("FAIL ovr_data_kept got=%h exp=07", chan(3)); end
        bus.out_ack[3] = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL ovr_ack_ready got=%b exp=1", bus.in_ready); end
        sb.push_back('{3, 6'h11});
        tick();
        bus.in_valid = 1'b0; bus.out_ack = '0;
        e = sb.pop_front();
        n_cmp++; if (chan(e.ch) !== e.data) begin n_mis++; $display("FAIL ovr_pass ch=%0d got=%h exp=%h", e.ch, chan(e.ch), e.data); end
        n_cmp++; if (bus.out_valid !== 16'h0008) begin n_mis++; $display("FAIL ovr_pass_valid got=%h exp=0008", bus.out_valid); end
        bus.out_ack[3] = 1'b1;
        tick();
        bus.out_ack = '0;
        n_cmp++; if (bus.overrun !== 1'b1) begin n_mis++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_auto_frame();
        int pulses;
        pulses = 0;
        bus.out_ack = '1; bus.auto_mode = 1'b1; bus.select = 4'd9;
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.datain = 6'(i); bus.in_valid = 1'b1;
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL auto_ready i=%0d got=%b exp=1", i, bus.in_ready); end
            sb.push_back('{i, 6'(i)});
            tick();
            e = sb.pop_front();
            n_cmp++; if (chan(e.ch) !== e.data || bus.out_valid[e.ch] !== 1'b1) begin n_mis++; $display("FAIL auto_data ch=%0d got=%h/%b exp=%h/1", e.ch, chan(e.ch), bus.out_valid[e.ch], e.data); end
            n_cmp++; if (bus.frame_done !== (i == 15)) begin n_mis++; $display("FAIL auto_frame_done i=%0d got=%b exp=%b", i, bus.frame_done, (i == 15)); end
            if (bus.frame_done === 1'b1) pulses++;
        end
        bus.in_valid = 1'b0;
        tick();
        if (bus.frame_done === 1'b1) pulses++;
        n_cmp++; if (pulses != 1) begin n_mis++; $display("FAIL auto_pulse_count got=%0d exp=1", pulses); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_mis++; $display("FAIL auto_overrun got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_mode_switch();
        bus.select = 4'd12;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) bus.auto_mode = 1'b0;
            bus.datain = 6'(8'h20 + i); bus.in_valid = 1'b1;
            sb.push_back('{i, 6'(8'h20 + i)});
            tick();
            e = sb.pop_front();
            n_cmp++; if (chan(e.ch) !== e.data || bus.out_valid[e.ch] !== 1'b1) begin n_mis++; $display("FAIL sw_auto ch=%0d got=%h/%b exp=%h/1", e.ch, chan(e.ch), bus.out_valid[e.ch], e.data); end
            n_cmp++; if (bus.frame_done !== (i == 15)) begin n_mis++; $display("FAIL sw_frame_done i=%0d got=%b exp=%b", i, bus.frame_done, (i == 15)); end
        end
        bus.datain = 6'h15;
        sb.push_back('{12, 6'h15});
        tick();
        e = sb.pop_front();
        n_cmp++; if (chan(e.ch) !== e.data) begin n_mis++; $display("FAIL sw_manual ch=%0d got=%h exp=%h", e.ch, chan(e.ch), e.data); end
        n_cmp++; if (chan(0) !== 6'h20) begin n_mis++; $display("FAIL sw_ch0_untouched got=%h exp=20", chan(0)); end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ack = '0;
    endtask

    task automatic test_async_reset();
        bus.auto_mode = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.datain = 6'(8'h30 + i); bus.in_valid = 1'b1;
            sb.push_back('{i, 6'(8'h30 + i)});
            tick();
            e = sb.pop_front();
            n_cmp++; if (chan(e.ch) !== e.data) begin n_mis++; $display("FAIL ar_fill ch=%0d got=%h exp=%h", e.ch, chan(e.ch), e.data); end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 16'h0007) begin n_mis++; $display("FAIL ar_pre_valid got=%h exp=0007", bus.out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 16'h0000) begin n_mis++; $display("FAIL ar_valid got=%h exp=0000", bus.out_valid); end
        n_cmp++; if (bus.dataout !== 96'h0) begin n_mis++; $display("FAIL ar_dataout got=%h exp=0", bus.dataout); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_mis++; $display("FAIL ar_overrun got=%b exp=0", bus.overrun); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_mis++; $display("FAIL ar_frame_done got=%b exp=0", bus.frame_done); end
        #1;
        rst = 1'b0;
        bus.auto_mode = 1'b0; bus.select = 4'd0; bus.datain = 6'h2A; bus.in_valid = 1'b1;
        sb.push_back('{0, 6'h2A});
        tick();
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (bus.out_valid !== 16'h0001) begin n_mis++; $display("FAIL ar_post_valid got=%h exp=0001", bus.out_valid); end
        n_cmp++; if (chan(e.ch) !== e.data) begin n_mis++; $display("FAIL ar_post_data ch=%0d got=%h exp=%h", e.ch, chan(e.ch), e.data); end
        bus.auto_mode = 1'b1; bus.select = 4'd7;
        tick();
        bus.datain = 6'h33; bus.in_valid = 1'b1; bus.out_ack = 16'h0001;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL ar_auto_ready got=%b exp=1", bus.in_ready); end
        sb.push_back('{0, 6'h33});
        tick();
        bus.in_valid = 1'b0; bus.out_ack = '0;
        e = sb.pop_front();
        n_cmp++; if (chan(e.ch) !== e.data || bus.out_valid !== 16'h0001) begin n_mis++; $display("FAIL ar_auto_ptr ch=%0d got=%h/%h exp=%h/0001", e.ch, chan(e.ch), bus.out_valid, e.data); end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_manual_write();
        test_overrun();
        test_auto_frame();
        test_mode_switch();
        test_async_reset();
        n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/demux_1_16_reg.md
# demux_1_16_reg

Registered 1:16 demultiplexer with per-channel valid/ack handshake: the distribution end of the 16:1 channel-select path. A single 6-bit producer stream is steered by a 4-bit select, or by an internal round-robin pointer, into 16 holding registers. Each register is drained independently by its consumer. The block sits between a shared-bus source and 16 per-channel consumers that earlier fed `MUX16_1_`-style selectors.

## Interface
Parameters:
- `WIDTH`, 6, data bits per channel
- `CHANNELS`, 16, number of output channels; `SEL_W` = log2(CHANNELS) = 4 (derived, not overridable)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  sole clock, rising edge
  - `rst`  in  1  asynchronous, active-high reset
- Producer side:
  - `datain`  in  WIDTH  producer word
  - `select`  in  SEL_W  target channel in manual mode
  - `in_valid`  in  1  producer has a word
  - `in_ready`  out  1  word accepted this cycle if `in_valid`; combinational
  - `auto_mode`  in  1  1 = round-robin pointer chooses channel, 0 = `select` chooses
- Consumer side:
  - `dataout`  out  CHANNELS*WIDTH  flattened holding registers; channel i at bits [i*WIDTH +: WIDTH]
  - `out_valid`  out  CHANNELS  channel i holds an unconsumed word
  - `out_ack`  in  CHANNELS  consumer i takes its word
- Status:
  - `frame_done`  out  1  one-cycle pulse after an auto-mode frame completes
  - `overrun`  out  1  sticky: manual-mode write stalled on a busy channel

## Operation
- FSM states: MANUAL, AUTO. Reset state is MANUAL.
- Target channel `tgt` is `select` in MANUAL and `ptr` in AUTO.
- `in_ready` = !out_valid[tgt] | out_ack[tgt].
- Accept occurs when `in_valid & in_ready`:
  - dataout[tgt] <= datain
  - out_valid[tgt] <= 1
- Ack on channel i with out_valid[i]=1 and no same-cycle accept on i: out_valid[i] <= 0. `dataout` keeps its last value.
- Simultaneous ack and accept on the same channel: out_valid stays 1 and data is replaced (pass-through, no bubble).
- Ack on a channel with out_valid=0: ignored.
- Acks on other channels are processed in parallel with any accept.
- FSM transitions:
  - MANUAL -> AUTO when auto_mode=1; ptr is forced to 0 on entry.
  - AUTO -> MANUAL only when auto_mode=0 and ptr=0 (frame boundary). A partial frame completes first.
- ptr increments on each accept in AUTO and wraps 15 -> 0 (SEL_W-bit natural wrap).
- The accept at ptr=15 raises frame_done for exactly the next cycle.
- overrun sets when in MANUAL with in_valid=1 and in_ready=0. It clears only on rst.
- Auto mode never sets overrun; the producer simply stalls.

## Timing
- Latency: a word accepted at edge N appears on dataout/out_valid after edge N; visible in cycle N+1.
- Ack sampled at edge N drops out_valid after edge N.
- in_ready is combinational from out_valid, out_ack, select, and state/ptr. There is no combinational path from in_valid.
- Reset values, applied asynchronously:
  - dataout all 0
  - out_valid 0
  - ptr 0
  - state MANUAL
  - frame_done 0
  - overrun 0
- Reset mid-frame discards all held words; the pointer returns to 0.
- The producer must hold datain/select stable while in_valid=1 and in_ready=0.

## Structure
- Package `demux_pkg`:
  - WIDTH, CHANNELS, SEL_W constants
  - mode enum {MANUAL, AUTO}
- Sub-module `demux_channel_slot`, instantiated CHANNELS times via generate. Each slot holds:
  - WIDTH-bit data register
  - valid flag
  - inputs wr_en, ack, d; outputs q, valid, busy
- Top level contains: FSM, ptr, tgt decode, in_ready mux, frame_done, overrun.

## Test plan
- Manual write and ack: select=5, datain=6'h2A, in_valid for 1 cycle -> next cycle out_valid=16'h0020 and dataout[35:30]=6'h2A. Pulse out_ack[5] -> out_valid=0, data retained.
- Busy stall and overrun: channel 3 full; write select=3, datain=6'h11 -> in_ready=0, overrun=1, data unchanged. Assert out_ack[3] same cycle -> accept; out_valid[3] stays 1, dataout ch3=6'h11.
- Auto frame: auto_mode=1, feed 16 words 6'h00..6'h0F back-to-back with all acks held high -> channel i receives i. frame_done pulses once, the cycle after the 16th accept. ptr wraps to 0.
- Mode switch mid-frame: in AUTO after 7 accepts, drop auto_mode -> state stays AUTO until 9 more accepts. MANUAL begins with ptr=0 and select honored.
- Async reset mid-operation: assert rst between edges with several out_valid set -> all outputs 0 immediately. First post-reset write to select=0 behaves as in the manual write test.
